multicycle_control: RTL



---
 rtl/multicycle_control.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I shared-memory datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables and mux selects. Memory accesses use a req/ready handshake with an
// optional wait-cycle timeout that raises a bus-error trap.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode            IR opcode field (valid from DECODE onward)
//   zero              ALU zero flag (branch decision)
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_write memory request / request is a store
//   adr_src           memory address select (0 PC, 1 ALUOut)
//   ir_write,pc_write IR+OldPC load, PC update
//   reg_write         register-file write
//   result_src        00 ALUOut, 01 read data, 10 ALU result
//   alu_src_a/b, alu_op  ALU operand selects and operation class
//   trap, trap_cause  trap indication and cause (01 illegal, 10 timeout)
//   state_dbg         current state encoding
module multicycle_control #(
    parameter bit          EN_JAL         = 1'b1,
    parameter bit          HALT_ON_TRAP   = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]          trap_cause_q, trap_cause_d;

    logic       timeout_c;
    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c;
    logic       reg_write_c, trap_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;

    // Last permitted wait cycle reached with no completion.
    assign timeout_c = (TIMEOUT_CYCLES != 0)
                    && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // State, wait counter and trap cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Next-state and output decode. wait_cnt defaults to 0, so it is clear
    // on every entry to a memory state and only counts while stalled.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        trap_cause_d = trap_cause_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        trap_c       = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_c) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                // Branch target OldPC+imm lands in ALUOut for BEQ.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL: begin
                        if (EN_JAL) begin
                            state_d = S_JAL;
                        end else begin
                            state_d      = S_TRAP;
                            trap_cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_c) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_c) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b11;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_write_c  = zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALUOut; ALU forms OldPC+4 for rd in ALUWB.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                trap_c = 1'b1;
                if (!HALT_ON_TRAP) begin
                    state_d      = S_FETCH;
                    trap_cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // All outputs are held at 0 while reset is asserted.
    assign mem_req    = rst_n & mem_req_c;
    assign mem_write  = rst_n & mem_write_c;
    assign adr_src    = rst_n & adr_src_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign trap       = rst_n & trap_c;
    assign result_src = rst_n ? result_src_c : 2'b00;
    assign alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
    assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
    assign alu_op     = rst_n ? alu_op_c     : 2'b00;
    assign trap_cause = rst_n ? trap_cause_q : 2'b00;
    assign state_dbg  = rst_n ? 4'(state_q)  : 4'd0;

endmodule
